sobel_edge_mask: RTL and testbench

- Streaming edge detector that sits directly upstream of the per-pixel blend stage in the style path.
- Takes raster RGB pixels, forms luma, and runs a 3x3 Sobel operator over two line buffers.
- Emits a binary edge mask per pixel: oGray = 255 for an edge, 0 otherwise.
- Also emits the matching RGB, delayed so that each mask value arrives in the same cycle as its own pixel for the blend stage.

---
 rtl/sobel_edge_mask.sv | 189 ++++++++++++++++++
 tb/tb_sobel_edge_mask.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_edge_mask.sv
// rtl/sobel_edge_mask.sv - streaming 3x3 Sobel edge mask with pixel-aligned RGB
// Optional edge statistics output oEDGE_CNT enabled by SOBEL_EDGE_STATS_EN.
module sobel_edge_mask #(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480
) (
   input  logic        iCLK,
   input  logic        iRST_N,
   input  logic        iDVAL,
   input  logic        iSOF,
   input  logic [7:0]  iR,
   input  logic [7:0]  iG,
   input  logic [7:0]  iB,
   input  logic [10:0] iTHRESH,
   output logic        oDVAL,
   output logic [7:0]  oR,
   output logic [7:0]  oG,
   output logic [7:0]  oB,
   output logic [7:0]  oGray
`ifdef SOBEL_EDGE_STATS_EN
   ,
   output logic [19:0] oEDGE_CNT
`endif
);

   localparam int D  = IMG_WIDTH + 1;
   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);
   localparam int DW = $clog2(D);
   localparam int PW = $clog2(D + 1);
   localparam int TW = 24 + CW + RW;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
   localparam logic [DW-1:0] DL_LAST  = DW'(D - 1);
   localparam logic [PW-1:0] PRIMED   = PW'(D);

   logic [CW-1:0]     col_q, col_d, lb_ptr_q, lb_ptr_d;
   logic [RW-1:0]     row_q, row_d;
   logic [DW-1:0]     dl_ptr_q, dl_ptr_d;
   logic [PW-1:0]     prime_q, prime_d;
   logic [8:0][7:0]   win_q, win_d;
   logic              s1_vld_q, s1_vld_d;
   logic [TW-1:0]     s1_tag_q, s1_tag_d;
   logic              odval_q, odval_d;
   logic [7:0]        or_q, or_d, og_q, og_d, ob_q, ob_d, gray_q, gray_d;
`ifdef SOBEL_EDGE_STATS_EN
   logic [19:0]       cnt_q, cnt_d, edge_cnt_q, edge_cnt_d;
`endif

   logic [7:0]        lb1_mem [IMG_WIDTH];
   logic [7:0]        lb2_mem [IMG_WIDTH];
   logic [TW-1:0]     dl_mem  [D];

   logic [9:0]        y10;
   logic [7:0]        y, lb1_rd, lb2_rd;
   logic [TW-1:0]     dl_rd;
   logic [CW-1:0]     cur_col, c_col;
   logic [RW-1:0]     cur_row, c_row;
   logic [10:0]       gx, gy, ax, ay, mag;
   logic              is_edge, c_last;

   always_comb begin
      y10     = {2'b0, iR} + {1'b0, iG, 1'b0} + {2'b0, iB};
      y       = 8'(y10 >> 2);
      lb1_rd  = lb1_mem[lb_ptr_q];
      lb2_rd  = lb2_mem[lb_ptr_q];
      dl_rd   = dl_mem[dl_ptr_q];
      cur_col = iSOF ? '0 : col_q;
      cur_row = iSOF ? '0 : row_q;

      col_d    = col_q;
      row_d    = row_q;
      lb_ptr_d = lb_ptr_q;
      dl_ptr_d = dl_ptr_q;
      prime_d  = prime_q;
      win_d    = win_q;
      s1_tag_d = s1_tag_q;
      s1_vld_d = iDVAL && (prime_q == PRIMED);
      if (iDVAL) begin
         col_d    = (cur_col == COL_LAST) ? '0 : cur_col + 1'b1;
         row_d    = (cur_col != COL_LAST) ? cur_row :
                    (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
         lb_ptr_d = (lb_ptr_q == COL_LAST) ? '0 : lb_ptr_q + 1'b1;
         dl_ptr_d = (dl_ptr_q == DL_LAST) ? '0 : dl_ptr_q + 1'b1;
         prime_d  = (prime_q == PRIMED) ? prime_q : prime_q + 1'b1;
         for (int r = 0; r < 3; r++) begin
            win_d[r*3+0] = win_q[r*3+1];
            win_d[r*3+1] = win_q[r*3+2];
         end
         // right-hand column: two lines ago, one line ago, current pixel
         win_d[2] = lb2_rd;
         win_d[5] = lb1_rd;
         win_d[8] = y;
         s1_tag_d = dl_rd;
      end

      gx = ({3'b0, win_q[2]} + {2'b0, win_q[5], 1'b0} + {3'b0, win_q[8]})
         - ({3'b0, win_q[0]} + {2'b0, win_q[3], 1'b0} + {3'b0, win_q[6]});
      gy = ({3'b0, win_q[6]} + {2'b0, win_q[7], 1'b0} + {3'b0, win_q[8]})
         - ({3'b0, win_q[0]} + {2'b0, win_q[1], 1'b0} + {3'b0, win_q[2]});
      ax  = gx[10] ? 11'(-gx) : gx;
      ay  = gy[10] ? 11'(-gy) : gy;
      mag = ax + ay;
      c_col   = s1_tag_q[CW+RW-1:RW];
      c_row   = s1_tag_q[RW-1:0];
      c_last  = (c_col == COL_LAST) && (c_row == ROW_LAST);
      is_edge = (mag >= iTHRESH) && (c_col != '0) && (c_col != COL_LAST)
                && (c_row != '0) && (c_row != ROW_LAST);

      odval_d = s1_vld_q;
      or_d    = or_q;
      og_d    = og_q;
      ob_d    = ob_q;
      gray_d  = gray_q;
      if (s1_vld_q) begin
         {or_d, og_d, ob_d} = s1_tag_q[TW-1 -: 24];
         gray_d = is_edge ? 8'd255 : 8'd0;
      end
`ifdef SOBEL_EDGE_STATS_EN
      cnt_d      = cnt_q;
      edge_cnt_d = edge_cnt_q;
      if (s1_vld_q) begin
         cnt_d = cnt_q + 20'(is_edge);
         if (c_last) begin
            edge_cnt_d = cnt_q + 20'(is_edge);
            cnt_d      = '0;
         end
      end
`endif
   end

   always_ff @(posedge iCLK) begin
      if (iDVAL) begin
         lb1_mem[lb_ptr_q] <= y;
         lb2_mem[lb_ptr_q] <= lb1_rd;
         dl_mem[dl_ptr_q]  <= {iR, iG, iB, cur_col, cur_row};
      end
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         col_q    <= '0;
         row_q    <= '0;
         lb_ptr_q <= '0;
         dl_ptr_q <= '0;
         prime_q  <= '0;
         win_q    <= '0;
         s1_vld_q <= 1'b0;
         s1_tag_q <= '0;
         odval_q  <= 1'b0;
         or_q     <= '0;
         og_q     <= '0;
         ob_q     <= '0;
         gray_q   <= '0;
`ifdef SOBEL_EDGE_STATS_EN
         cnt_q      <= '0;
         edge_cnt_q <= '0;
`endif
      end else begin
         col_q    <= col_d;
         row_q    <= row_d;
         lb_ptr_q <= lb_ptr_d;
         dl_ptr_q <= dl_ptr_d;
         prime_q  <= prime_d;
         win_q    <= win_d;
         s1_vld_q <= s1_vld_d;
         s1_tag_q <= s1_tag_d;
         odval_q  <= odval_d;
         or_q     <= or_d;
         og_q     <= og_d;
         ob_q     <= ob_d;
         gray_q   <= gray_d;
`ifdef SOBEL_EDGE_STATS_EN
         cnt_q      <= cnt_d;
         edge_cnt_q <= edge_cnt_d;
`endif
      end
   end

   assign oDVAL = odval_q;
   assign oR    = or_q;
   assign oG    = og_q;
   assign oB    = ob_q;
   assign oGray = gray_q;
`ifdef SOBEL_EDGE_STATS_EN
   assign oEDGE_CNT = edge_cnt_q;
`endif

endmodule

// File: tb/tb_sobel_edge_mask.sv
// tb/tb_sobel_edge_mask.sv - bench for sobel_edge_mask on an 8x6 image
module tb_sobel_edge_mask;

   localparam int W = 8;
   localparam int H = 6;
   localparam int D = W + 1;
   localparam int NPIX = W * H;

   logic        iCLK, iRST_N, iDVAL, iSOF;
   logic [7:0]  iR, iG, iB;
   logic [10:0] iTHRESH;
   logic        oDVAL;
   logic [7:0]  oR, oG, oB, oGray;
`ifdef SOBEL_EDGE_STATS_EN
   logic [19:0] oEDGE_CNT;
`endif

   sobel_edge_mask #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .iCLK(iCLK), .iRST_N(iRST_N), .iDVAL(iDVAL), .iSOF(iSOF),
      .iR(iR), .iG(iG), .iB(iB), .iTHRESH(iTHRESH),
      .oDVAL(oDVAL), .oR(oR), .oG(oG), .oB(oB), .oGray(oGray)
`ifdef SOBEL_EDGE_STATS_EN
      , .oEDGE_CNT(oEDGE_CNT)
`endif
   );

   initial iCLK = 1'b0;
   always #5 iCLK = ~iCLK;

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;
   int consec = 0;
   bit prev_dval = 0;
   logic [31:0] out_q[$];
   int out_cyc[$];
   int beat_cyc[$];
   logic [23:0] img [2][H][W];

   always @(posedge iCLK) cyc++;

   always @(negedge iCLK) begin
      if (oDVAL) begin
         out_q.push_back({oR, oG, oB, oGray});
         out_cyc.push_back(cyc);
         if (prev_dval) consec++;
      end
      prev_dval = oDVAL;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   function automatic int luma(input logic [23:0] p);
      return (int'(p[23:16]) + 2 * int'(p[15:8]) + int'(p[7:0])) / 4;
   endfunction

   // Reference: Sobel over true image neighbours, borders forced to zero
   function automatic int model_gray(input int f, input int r, input int c, input int thr);
      int gx, gy, l;
      if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 0;
      gx = 0;
      gy = 0;
      for (int dr = 0; dr < 3; dr++)
         for (int dc = 0; dc < 3; dc++) begin
            l = luma(img[f][r+dr-1][c+dc-1]);
            gx += l * (dc - 1) * ((dr == 1) ? 2 : 1);
            gy += l * (dr - 1) * ((dc == 1) ? 2 : 1);
         end
      if (gx < 0) gx = -gx;
      if (gy < 0) gy = -gy;
      return (gx + gy >= thr) ? 255 : 0;
   endfunction

   function automatic int model_edges(input int f, input int thr);
      int n = 0;
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            if (model_gray(f, r, c, thr) == 255) n++;
      return n;
   endfunction

   task automatic fill(input int pat);
      for (int f = 0; f < 2; f++)
         for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
               case (pat)
                  0: img[f][r][c] = 24'hFF0000;
                  1: img[f][r][c] = {3{8'd100}};
                  2: img[f][r][c] = (c < 4) ? 24'h000000 : 24'hFFFFFF;
                  default: img[f][r][c] = 24'($urandom);
               endcase
   endtask

   task automatic beat(input logic [23:0] p, input logic sof, input int mode);
      int gaps;
      @(posedge iCLK); #1;
      iDVAL = 1'b1;
      iSOF = sof;
      {iR, iG, iB} = p;
      beat_cyc.push_back(cyc);
      gaps = (mode == 1) ? 1 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
      repeat (gaps) begin
         @(posedge iCLK); #1;
         iDVAL = 1'b0;
         iSOF = 1'b0;
         {iR, iG, iB} = 24'($urandom);
      end
   endtask

   task automatic do_reset(input int idx);
      @(posedge iCLK); #1;
      iRST_N = 1'b0;
      iDVAL = 1'b0;
      iSOF = 1'b0;
      repeat (2) @(posedge iCLK);
      #1;
      check($sformatf("reset_state[%0d]", idx), {23'b0, oDVAL, oR, oG, oB, oGray}, 32'h0);
      iRST_N = 1'b1;
   endtask

   task automatic run_frames(input int idx, input int nfr, input int mode, input int thr, input int exp_edges);
      int ob, bb, n, k, nedge, c0;
      logic [31:0] exp;
      iTHRESH = 11'(thr);
      ob = out_q.size();
      bb = beat_cyc.size();
      c0 = consec;
      for (int f = 0; f < nfr; f++)
         for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
               beat(img[f][r][c], (r == 0 && c == 0), mode);
      for (int j = 0; j < D; j++) beat(24'h0, (j == 0), mode);
      @(posedge iCLK); #1;
      iDVAL = 1'b0;
      iSOF = 1'b0;
      repeat (6) @(posedge iCLK);
      #1;
      n = out_q.size() - ob;
      check($sformatf("out_count[%0d]", idx), n, nfr * NPIX);
      if (n > 0)
         check($sformatf("first_dval_cycle[%0d]", idx), out_cyc[ob], beat_cyc[bb + D] + 2);
      if (mode == 1)
         check($sformatf("no_back_to_back[%0d]", idx), consec - c0, 0);
      for (int f = 0; f < nfr; f++) begin
         nedge = 0;
         for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
               k = ob + f * NPIX + r * W + c;
               exp = {img[f][r][c], 8'(model_gray(f, r, c, thr))};
               if (k < out_q.size()) begin
                  check($sformatf("pix[%0d] f%0d r%0d c%0d", idx, f, r, c), out_q[k], exp);
                  if (out_q[k][7:0] == 8'd255) nedge++;
               end
            end
         if (exp_edges >= 0)
            check($sformatf("edge_count[%0d] f%0d", idx, f), nedge, exp_edges);
      end
`ifdef SOBEL_EDGE_STATS_EN
      check($sformatf("stats_cnt[%0d]", idx), oEDGE_CNT, model_edges(nfr - 1, thr));
`endif
   endtask

   typedef struct {
      int pat;
      int nfr;
      int thr;
      int mode;
      int exp_edges;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int thr;
      vecs[0] = '{0, 1, 200, 0, 0};
      vecs[1] = '{1, 2, 200, 0, 0};
      vecs[2] = '{2, 1, 200, 0, 8};
      vecs[3] = '{2, 1, 1021, 0, 0};
      vecs[4] = '{2, 1, 1020, 0, 8};
      vecs[5] = '{2, 1, 200, 1, 8};
      vecs[6] = '{3, 2, -1, 2, -1};
      vecs[7] = '{3, 1, 0, 0, (W - 2) * (H - 2)};

      iRST_N = 1'b1;
      iDVAL = 1'b0;
      iSOF = 1'b0;
      {iR, iG, iB} = 24'h0;
      iTHRESH = 11'd200;
      #2;

      for (int i = 0; i < 8; i++) begin
         fill(vecs[i].pat);
         thr = (vecs[i].thr < 0) ? int'($urandom_range(100, 700)) : vecs[i].thr;
         do_reset(i);
         run_frames(i, vecs[i].nfr, vecs[i].mode, thr, vecs[i].exp_edges);
      end

      // reset pulse in the middle of row 3, then a clean frame
      fill(3);
      do_reset(8);
      iTHRESH = 11'd200;
      for (int j = 0; j < 3 * W + 3; j++) beat(img[1][j / W][j % W], (j == 0), 0);
      @(posedge iCLK); #1;
      iRST_N = 1'b0;
      iDVAL = 1'b0;
      #1;
      check("mid_reset_outputs", {23'b0, oDVAL, oR, oG, oB, oGray}, 32'h0);
      @(posedge iCLK); #1;
      iRST_N = 1'b1;
      run_frames(9, 1, 0, 200, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
